dual_priority_scanner: RTL
==========================

Name: dual_priority_scanner

Overview:
- Parametrised, sequential successor to the dual priority encoder. It latches a WIDTH-bit request vector and streams the indices of every set bit, two per beat, in priority order.
- Each output beat carries the highest and second-highest remaining set bits. It uses a valid/ready handshake on both sides.
- Sits between a request-collection stage and a per-index service engine, so multi-hit vectors are fully drained instead of reporting only the top two hits.

Parameters:
- WIDTH, 12: request vector width; must be at least 2.
- IDX_W, 4: index width; must be at least clog2(WIDTH).
- MSB_FIRST, 1: 1 means bit WIDTH-1 has highest priority; 0 means bit 0 has highest priority.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_vec  in  WIDTH  request vector; sampled on accept.
- req_valid  in  1  req_vec is valid.
- req_ready  out  1  block can accept a vector; high only in IDLE.
- abort  in  1  synchronous flush of the current vector.
- out_valid  out  1  output beat is valid.
- out_ready  in  1  consumer accepts the beat.
- prior_1  out  IDX_W  index of the highest-priority remaining set bit.
- prior_2  out  IDX_W  index of the second-highest remaining set bit.
- p1_valid  out  1  prior_1 is meaningful.
- p2_valid  out  1  prior_2 is meaningful.
- last  out  1  this beat exhausts the vector.

Behaviour:
- Registers:
  - state, one of IDLE and SCAN.
  - resid, WIDTH bits: the residual request bits.
  - empty_pend, 1 bit: set when an all-zero vector was accepted.
- Reset (asynchronous, while reset is high): state=IDLE, resid=0, empty_pend=0. Outputs during and after reset: req_ready=1, out_valid=0, prior_1=prior_2=0, p1_valid=p2_valid=0, last=0.
- IDLE:
  - req_ready=1 and out_valid=0.
  - On rising edge with req_valid=1: resid<=req_vec, empty_pend<=(req_vec==0), state<=SCAN.
- SCAN, outputs:
  - req_ready=0 and out_valid=1.
  - All outputs are combinational functions of registers only; no combinational path from req_* or out_ready to outputs.
  - prior_1 is the highest-priority set bit of resid, per MSB_FIRST.
  - prior_2 is the highest-priority set bit of resid with the prior_1 bit masked.
  - p1_valid = (popcount(resid) >= 1); p2_valid = (popcount(resid) >= 2).
  - An invalid index field drives 0.
  - last = 1 when popcount(resid) <= 2, which includes the empty_pend case.
- SCAN, transitions:
  - Beat transfers on the rising edge where out_valid && out_ready.
  - On transfer: clear the prior_1 and prior_2 bits (only those flagged valid) in resid.
  - If last=1 on transfer: state<=IDLE and empty_pend<=0.
- Stall: while out_valid=1 and out_ready=0, all outputs hold stable.
- Latency:
  - Vector accepted at edge k gives the first beat valid in cycle k+1.
  - Last beat accepted at edge m gives req_ready=1 in cycle m+1. There is exactly one bubble between vectors; there is no same-cycle re-accept.
- Beat count per vector is max(1, ceil(popcount/2)). An all-zero vector yields exactly one beat with p1_valid=p2_valid=0, last=1, indices 0.
- Abort:
  - abort=1 in SCAN on a rising edge: resid<=0, empty_pend<=0, state<=IDLE, regardless of out_ready. That beat is not considered transferred.
  - abort in IDLE is ignored, and any simultaneous req accept still occurs.
  - abort takes precedence over transfer in the same cycle.
- Reset mid-SCAN discards the vector immediately; outputs return to reset values asynchronously.
- Indices are unsigned bit positions 0..WIDTH-1, zero-extended to IDX_W.

Test Plan (WIDTH=12, IDX_W=4 unless stated):
1. MSB_FIRST=1, req_vec=12'b110000000000, out_ready=1 -> one beat: prior_1=11, prior_2=10, p1_valid=1, p2_valid=1, last=1. req_ready low for exactly 1 cycle after accept, then high.
2. MSB_FIRST=1, req_vec=12'b010000000001 -> one beat: prior_1=10, prior_2=0, both valid, last=1. Then req_vec=12'b000000000000 -> one beat: p1_valid=0, p2_valid=0, prior_1=prior_2=0, last=1.
3. MSB_FIRST=1, req_vec=12'b111111111111, out_ready toggling 1,0,0,1,... -> six beats in order (11,10),(9,8),(7,6),(5,4),(3,2),(1,0), last only on (1,0). Outputs are stable during every out_ready=0 cycle.
4. req_vec=12'b000010000101:
   - MSB_FIRST=1 -> beats (7,2) last=0, then (0,-) with p2_valid=0, last=1.
   - MSB_FIRST=0 -> beats (0,2) last=0, then (7,-) with p2_valid=0, last=1.
5. req_vec=12'hFFF accepted. After the second beat, assert abort together with out_ready=1 -> next cycle out_valid=0, req_ready=1. A new vector 12'b000000000100 then yields a single beat with prior_1=2, p2_valid=0, last=1, with no stale bits.
6. Assert reset asynchronously mid-SCAN (between clock edges) -> out_valid, p1_valid, p2_valid, last drop to 0 and req_ready=1 without waiting for a clock edge. After reset deasserts, normal operation from test 1 reproduces exactly.

Source files
------------

// File: rtl/dual_priority_scanner.sv
// -----------------------------------------------------------------------------
// dual_priority_scanner
//
// Latches a WIDTH-bit request vector and streams the indices of every set bit,
// two per output beat, highest priority first. The vector is fully drained
// over max(1, ceil(popcount/2)) beats. There is one idle cycle between
// vectors.
//
// Parameters:
//   WIDTH     - request vector width (>= 2)
//   IDX_W     - index width (>= clog2(WIDTH))
//   MSB_FIRST - 1: bit WIDTH-1 has highest priority, 0: bit 0 has highest
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   req_vec    in   request vector, sampled on accept
//   req_valid  in   req_vec is valid
//   req_ready  out  block can accept a vector (IDLE only)
//   abort      in   synchronous flush of the vector being scanned
//   out_valid  out  output beat is valid
//   out_ready  in   consumer accepts the beat
//   prior_1    out  highest-priority remaining set bit index
//   prior_2    out  second-highest remaining set bit index
//   p1_valid   out  prior_1 is meaningful
//   p2_valid   out  prior_2 is meaningful
//   last       out  this beat exhausts the vector
//
// All outputs are decoded from registers only; there is no combinational path
// from req_* or out_ready to any output.
// -----------------------------------------------------------------------------
module dual_priority_scanner #(
    parameter int WIDTH     = 12,
    parameter int IDX_W     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] req_vec,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] prior_1,
    output logic [IDX_W-1:0] prior_2,
    output logic             p1_valid,
    output logic             p2_valid,
    output logic             last
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    state_e           state_q,      state_d;
    logic [WIDTH-1:0] resid_q,      resid_d;
    logic             empty_pend_q, empty_pend_d;

    logic [WIDTH-1:0] one_s;
    logic [IDX_W-1:0] prior_1_s;
    logic [IDX_W-1:0] prior_2_s;
    logic             p1_valid_s;
    logic             p2_valid_s;
    logic [WIDTH-1:0] mask_1_s;
    logic [WIDTH-1:0] mask_2_s;
    logic [WIDTH-1:0] rest_1_s;
    logic [WIDTH-1:0] rest_2_s;
    logic             last_s;
    logic             in_scan_s;

    // Index of the highest-priority set bit; returns 0 for an all-zero vector.
    // The loop walks from lowest to highest priority so the final hit wins.
    function automatic logic [IDX_W-1:0] top_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                if (v[i]) begin
                    idx = IDX_W'(i);
                end else begin
                    idx = idx;
                end
            end else begin
                if (v[WIDTH-1-i]) begin
                    idx = IDX_W'(WIDTH-1-i);
                end else begin
                    idx = idx;
                end
            end
        end
        return idx;
    endfunction

    assign one_s = {{(WIDTH-1){1'b0}}, 1'b1};

    // Priority decode of the residual: pick top bit, mask it, pick again.
    always_comb begin
        p1_valid_s = |resid_q;
        prior_1_s  = top_idx(resid_q);
        mask_1_s   = p1_valid_s ? (one_s << prior_1_s) : {WIDTH{1'b0}};
        rest_1_s   = resid_q & ~mask_1_s;
        p2_valid_s = |rest_1_s;
        prior_2_s  = top_idx(rest_1_s);
        mask_2_s   = p2_valid_s ? (one_s << prior_2_s) : {WIDTH{1'b0}};
        rest_2_s   = rest_1_s & ~mask_2_s;
        // Nothing left after this beat means popcount <= 2 (incl. empty vector).
        last_s     = (rest_2_s == {WIDTH{1'b0}}) || empty_pend_q;
    end

    // Next-state logic: accept in IDLE, drain/abort in SCAN.
    always_comb begin
        state_d      = state_q;
        resid_d      = resid_q;
        empty_pend_d = empty_pend_q;
        case (state_q)
            ST_IDLE: begin
                // abort is ignored here; a simultaneous accept still happens
                if (req_valid) begin
                    resid_d      = req_vec;
                    empty_pend_d = (req_vec == {WIDTH{1'b0}});
                    state_d      = ST_SCAN;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_SCAN: begin
                // abort wins over a beat transfer in the same cycle
                if (abort) begin
                    resid_d      = {WIDTH{1'b0}};
                    empty_pend_d = 1'b0;
                    state_d      = ST_IDLE;
                end else if (out_ready) begin
                    resid_d = rest_2_s;
                    if (last_s) begin
                        empty_pend_d = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d      = ST_SCAN;
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
            default: begin
                resid_d      = {WIDTH{1'b0}};
                empty_pend_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            resid_q      <= {WIDTH{1'b0}};
            empty_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            resid_q      <= resid_d;
            empty_pend_q <= empty_pend_d;
        end
    end

    assign in_scan_s = (state_q == ST_SCAN);

    // Outputs are forced to their idle values outside SCAN.
    assign req_ready = ~in_scan_s;
    assign out_valid = in_scan_s;
    assign p1_valid  = in_scan_s & p1_valid_s;
    assign p2_valid  = in_scan_s & p2_valid_s;
    assign last      = in_scan_s & last_s;
    assign prior_1   = in_scan_s ? prior_1_s : {IDX_W{1'b0}};
    assign prior_2   = in_scan_s ? prior_2_s : {IDX_W{1'b0}};

endmodule
